conv_inst_arb: RTL and testbench

- Round-robin arbiter that merges IN independent convolution-instruction streams into one 40-bit valid/ready stream feeding the conv instruction loop engine.
- Sources are, for example, the host instruction loader and a replay/loop source.
- Instructions travel in groups. A group is one or more words, terminated by a word with the LAST flag set. A group is never interleaved with another source's words.
- Output is one registered stage: 1-cycle latency, full throughput.

---
 rtl/conv_inst_arb.sv | 157 +++++++++++++++
 tb/tb_conv_inst_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_inst_arb.sv
// conv_inst_arb
//   Round-robin arbiter merging IN convolution-instruction sources into a
//   single registered valid/ready stream for the conv instruction loop
//   engine. Instructions travel in groups terminated by a word carrying the
//   LAST flag at bit LB; once a source wins, the arbiter stays locked to it
//   until that LAST word has been accepted, so groups never interleave.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   m_inst   : source instructions, source k at [k*IW +: IW]
//   m_valid  : per-source valid
//   m_ready  : per-source ready (one-hot or zero)
//   s_inst   : registered merged instruction
//   s_valid  : s_inst valid
//   s_ready  : downstream ready
//   s_src    : index of the source that produced s_inst
//   busy     : high while locked to a source mid-group
module conv_inst_arb #(
   parameter int IN = 2,
   parameter int IW = 40,
   parameter int LB = 39,
   parameter int SW = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN*IW-1:0] m_inst,
   input  logic [IN-1:0]    m_valid,
   output logic [IN-1:0]    m_ready,
   output logic [IW-1:0]    s_inst,
   output logic             s_valid,
   input  logic             s_ready,
   output logic [SW-1:0]    s_src,
   output logic             busy
);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t         state_q, state_d;
   logic [SW-1:0]  ptr_q, ptr_d;
   logic [SW-1:0]  g_q, g_d;
   logic [IW-1:0]  s_inst_q, s_inst_d;
   logic           s_valid_q, s_valid_d;
   logic [SW-1:0]  s_src_q, s_src_d;

   logic           load;
   logic           found;
   logic [SW-1:0]  win;
   logic [SW:0]    cand;
   logic [SW-1:0]  sel;
   logic           grant_en;
   logic           acc;
   logic [IW-1:0]  sel_word;

   // Explicit wrap so that non-power-of-two IN never lands on an unused index.
   function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] v);
      if (v == SW'(IN - 1)) return '0;
      else                  return v + 1'b1;
   endfunction

   // Output register is free when empty or being drained this cycle.
   assign load = !s_valid_q || s_ready;

   // Round-robin scan starting at ptr; first valid source wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 0; i < IN; i++) begin
         cand = (SW+1)'(ptr_q) + (SW+1)'(i);
         if (cand >= (SW+1)'(IN)) cand = cand - (SW+1)'(IN);
         if (!found && m_valid[cand[SW-1:0]]) begin
            found = 1'b1;
            win   = cand[SW-1:0];
         end
      end
   end

   // While locked only the owning source is looked at; in LOCK its ready
   // follows load even if it is momentarily not valid.
   assign sel      = (state_q == LOCK) ? g_q : win;
   assign grant_en = (state_q == LOCK) || found;
   assign acc      = grant_en && load && m_valid[sel];

   always_comb begin
      sel_word = '0;
      m_ready  = '0;
      for (int k = 0; k < IN; k++) begin
         if (sel == SW'(k)) begin
            sel_word   = m_inst[k*IW +: IW];
            m_ready[k] = grant_en && load;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      g_d       = g_q;
      s_inst_d  = s_inst_q;
      s_valid_d = s_valid_q;
      s_src_d   = s_src_q;

      if (acc) begin
         s_inst_d  = sel_word;
         s_src_d   = sel;
         s_valid_d = 1'b1;
      end else if (s_ready) begin
         s_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (acc) begin
               if (sel_word[LB]) begin
                  ptr_d = wrap_inc(win);
               end else begin
                  state_d = LOCK;
                  g_d     = win;
               end
            end
         end
         LOCK: begin
            if (acc && sel_word[LB]) begin
               state_d = IDLE;
               ptr_d   = wrap_inc(g_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stage boundary: arbitration -> registered output slice
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         g_q       <= '0;
         s_inst_q  <= '0;
         s_valid_q <= 1'b0;
         s_src_q   <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         g_q       <= g_d;
         s_inst_q  <= s_inst_d;
         s_valid_q <= s_valid_d;
         s_src_q   <= s_src_d;
      end
   end

   assign s_inst  = s_inst_q;
   assign s_valid = s_valid_q;
   assign s_src   = s_src_q;
   assign busy    = (state_q == LOCK);

endmodule

// File: tb/tb_conv_inst_arb.sv
module tb_conv_inst_arb;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // IN=2 instance
   logic [79:0]  m_inst2;
   logic [1:0]   m_valid2, m_ready2;
   logic [39:0]  s_inst2;
   logic         s_valid2, s_ready2, busy2;
   logic [0:0]   s_src2;

   // IN=3 instance
   logic [119:0] m_inst3;
   logic [2:0]   m_valid3, m_ready3;
   logic [39:0]  s_inst3;
   logic         s_valid3, s_ready3, busy3;
   logic [1:0]   s_src3;

   conv_inst_arb #(.IN(2), .IW(40), .LB(39), .SW(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .m_inst(m_inst2), .m_valid(m_valid2),
      .m_ready(m_ready2), .s_inst(s_inst2), .s_valid(s_valid2),
      .s_ready(s_ready2), .s_src(s_src2), .busy(busy2));

   conv_inst_arb #(.IN(3), .IW(40), .LB(39), .SW(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .m_inst(m_inst3), .m_valid(m_valid3),
      .m_ready(m_ready3), .s_inst(s_inst3), .s_valid(s_valid3),
      .s_ready(s_ready3), .s_src(s_src3), .busy(busy3));

   logic [39:0] sq0[$], sq1[$];
   logic [39:0] tq0[$], tq1[$], tq2[$];
   logic [41:0] e2[$], e3[$];
   logic [1:0]  mr2_seen;
   logic [2:0]  mr3_seen;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] w(input logic last, input logic [38:0] v);
      return {last, v};
   endfunction

   // Entered at a negedge: drive sources, score consumed output, advance.
   task automatic cycle();
      logic [1:0]  acc2;
      logic [2:0]  acc3;
      logic [41:0] e;
      m_inst2  = '0;
      m_valid2 = {sq1.size() > 0, sq0.size() > 0};
      if (sq0.size() > 0) m_inst2[39:0]  = sq0[0];
      if (sq1.size() > 0) m_inst2[79:40] = sq1[0];
      m_inst3  = '0;
      m_valid3 = {tq2.size() > 0, tq1.size() > 0, tq0.size() > 0};
      if (tq0.size() > 0) m_inst3[39:0]   = tq0[0];
      if (tq1.size() > 0) m_inst3[79:40]  = tq1[0];
      if (tq2.size() > 0) m_inst3[119:80] = tq2[0];
      #1;
      mr2_seen = m_ready2;
      mr3_seen = m_ready3;
      acc2 = m_valid2 & m_ready2;
      acc3 = m_valid3 & m_ready3;
      if ($countones(m_ready2) > 1) check("onehot2", 64'(m_ready2), 64'(0));
      if ($countones(m_ready3) > 1) check("onehot3", 64'(m_ready3), 64'(0));
      if (s_valid2 && s_ready2) begin
         if (e2.size() == 0) check("extra2", 64'(s_inst2), 64'(0));
         else begin
            e = e2.pop_front();
            check("src2", 64'(s_src2), 64'(e[41:40]));
            check("inst2", 64'(s_inst2), 64'(e[39:0]));
         end
      end
      if (s_valid3 && s_ready3) begin
         if (e3.size() == 0) check("extra3", 64'(s_inst3), 64'(0));
         else begin
            e = e3.pop_front();
            check("src3", 64'(s_src3), 64'(e[41:40]));
            check("inst3", 64'(s_inst3), 64'(e[39:0]));
         end
      end
      @(posedge clk);
      if (acc2[0]) void'(sq0.pop_front());
      if (acc2[1]) void'(sq1.pop_front());
      if (acc3[0]) void'(tq0.pop_front());
      if (acc3[1]) void'(tq1.pop_front());
      if (acc3[2]) void'(tq2.pop_front());
      @(negedge clk);
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((e2.size() > 0 || e3.size() > 0 || s_valid2 || s_valid3) && n < budget) begin
         cycle();
         n++;
      end
      check(tag, 64'(e2.size() + e3.size()), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      logic [39:0] a;
      rst_n    = 1'b0;
      s_ready2 = 1'b1;
      s_ready3 = 1'b1;
      m_inst2  = '0; m_valid2 = '0;
      m_inst3  = '0; m_valid3 = '0;
      repeat (2) @(negedge clk);
      check("rst_valid", 64'(s_valid2), 64'(0));
      check("rst_busy", 64'(busy2), 64'(0));
      rst_n = 1'b1;
      check("rst_inst", 64'(s_inst2), 64'(0));
      check("rst_src", 64'(s_src2), 64'(0));
      check("rst_mready", 64'(m_ready2), 64'(0));

      // 1: single word from source 0
      sq0.push_back(40'h80_0000_0001);
      e2.push_back({2'd0, 40'h80_0000_0001});
      cycle();
      check("t1_valid", 64'(s_valid2), 64'(1));
      check("t1_inst", 64'(s_inst2), 64'h80_0000_0001);
      check("t1_src", 64'(s_src2), 64'(0));
      cycle();
      check("t1_empty", 64'(s_valid2), 64'(0));
      drain("t1_drain", 10);

      // 2: round robin, ptr now 1 so source 1 leads
      for (int i = 0; i < 3; i++) sq1.push_back(w(1'b1, 39'(16'h1100 + i)));
      for (int i = 0; i < 2; i++) sq0.push_back(w(1'b1, 39'(16'h0100 + i)));
      e2.push_back({2'd1, w(1'b1, 39'h1100)});
      e2.push_back({2'd0, w(1'b1, 39'h0100)});
      e2.push_back({2'd1, w(1'b1, 39'h1101)});
      e2.push_back({2'd0, w(1'b1, 39'h0101)});
      e2.push_back({2'd1, w(1'b1, 39'h1102)});
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("t2_nobubble", 64'(s_valid2), 64'(1));
      end
      drain("t2_drain", 10);

      // 3: group lock on source 0 while source 1 waits
      sq0.push_back(w(1'b0, 39'h0A0));
      sq0.push_back(w(1'b0, 39'h0A1));
      sq0.push_back(w(1'b1, 39'h0A2));
      sq1.push_back(w(1'b1, 39'h1B0));
      e2.push_back({2'd0, w(1'b0, 39'h0A0)});
      e2.push_back({2'd0, w(1'b0, 39'h0A1)});
      e2.push_back({2'd0, w(1'b1, 39'h0A2)});
      e2.push_back({2'd1, w(1'b1, 39'h1B0)});
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("t3_mready", 64'(mr2_seen), 64'(1));
         check("t3_busy", 64'(busy2), 64'(i < 2));
      end
      cycle();
      check("t3_follow_src", 64'(s_src2), 64'(1));
      check("t3_follow_vld", 64'(s_valid2), 64'(1));
      drain("t3_drain", 10);

      // 4: backpressure; ptr back at 0 so source 0 wins first
      sq0.push_back(w(1'b1, 39'h0C0));
      sq1.push_back(w(1'b1, 39'h1C0));
      sq0.push_back(w(1'b1, 39'h0C1));
      e2.push_back({2'd0, w(1'b1, 39'h0C0)});
      e2.push_back({2'd1, w(1'b1, 39'h1C0)});
      e2.push_back({2'd0, w(1'b1, 39'h0C1)});
      cycle();
      a = s_inst2;
      check("t4_first", 64'(a), 64'(w(1'b1, 39'h0C0)));
      s_ready2 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("t4_hold_inst", 64'(s_inst2), 64'(w(1'b1, 39'h0C0)));
         check("t4_hold_src", 64'(s_src2), 64'(0));
         check("t4_mready", 64'(mr2_seen), 64'(0));
      end
      s_ready2 = 1'b1;
      cycle();
      check("t4_release_acc", 64'(mr2_seen), 64'(2));
      check("t4_next_src", 64'(s_src2), 64'(1));
      check("t4_next_vld", 64'(s_valid2), 64'(1));
      drain("t4_drain", 10);

      // 5: reset in the middle of a source-1 group
      sq1.push_back(w(1'b0, 39'h1D0));
      sq1.push_back(w(1'b0, 39'h1D1));
      sq1.push_back(w(1'b1, 39'h1D2));
      cycle();
      check("t5_busy", 64'(busy2), 64'(1));
      check("t5_valid", 64'(s_valid2), 64'(1));
      rst_n = 1'b0;
      #1;
      check("t5_async_valid", 64'(s_valid2), 64'(0));
      check("t5_async_busy", 64'(busy2), 64'(0));
      check("t5_async_src", 64'(s_src2), 64'(0));
      sq1.delete();
      @(negedge clk);
      rst_n = 1'b1;
      sq0.push_back(w(1'b1, 39'h0E0));
      sq1.push_back(w(1'b1, 39'h1E0));
      e2.push_back({2'd0, w(1'b1, 39'h0E0)});
      e2.push_back({2'd1, w(1'b1, 39'h1E0)});
      drain("t5_drain", 10);

      // 6: IN=3, move ptr to 2 then contend sources 1 and 2
      tq1.push_back(w(1'b1, 39'h1F0));
      e3.push_back({2'd1, w(1'b1, 39'h1F0)});
      drain("t6_prep", 10);
      tq1.push_back(w(1'b1, 39'h1F1));
      tq1.push_back(w(1'b1, 39'h1F2));
      tq2.push_back(w(1'b1, 39'h2F1));
      tq2.push_back(w(1'b1, 39'h2F2));
      e3.push_back({2'd2, w(1'b1, 39'h2F1)});
      e3.push_back({2'd1, w(1'b1, 39'h1F1)});
      e3.push_back({2'd2, w(1'b1, 39'h2F2)});
      e3.push_back({2'd1, w(1'b1, 39'h1F2)});
      drain("t6_drain", 12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
